// File: rtl/adder_tree_pkg.sv
// Shared defaults and width helpers for the pipelined adder tree.
// The optional accumulator is enabled by defining ADDER_TREE_ACC_EN.
package adder_tree_pkg;

    localparam int DEF_WIDTH    = 15;
    localparam int DEF_LEVELS   = 3;
    localparam int DEF_ACC_BITS = 8;

    // Width of the partial sums leaving adder level lv (lv = 0 is the operands).
    function automatic int stage_w(input int width, input int lv);
        return width + lv;
    endfunction

    // Bit offset of level lv inside a flat bus holding every level back to back.
    function automatic int level_off(input int width, input int n, input int lv);
        int off;
        off = 0;
        for (int j = 0; j < lv; j++) begin
            off += (n >> j) * stage_w(width, j);
        end
        return off;
    endfunction

endpackage

// File: rtl/adder_tree_node.sv
// One registered unsigned two-input adder with its own valid bit and hold enable.
// The result is one bit wider than the operands, so nothing is ever truncated.
module adder_tree_node
    import adder_tree_pkg::*;
#(
    parameter int IN_W     = DEF_WIDTH,
    parameter bit RST_DATA = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            in_vld,
    input  logic [IN_W-1:0] a,
    input  logic [IN_W-1:0] b,
    output logic            out_vld,
    output logic [IN_W:0]   sum
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
        end else if (en) begin
            out_vld <= in_vld;
        end
    end

    // Only the last level clears its data; it is what the consumer sees.
    if (RST_DATA) begin : g_rst_data
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum <= '0;
            end else if (en && in_vld) begin
                sum <= {1'b0, a} + {1'b0, b};
            end
        end
    end else begin : g_free_data
        always_ff @(posedge clk) begin
            if (en && in_vld) begin
                sum <= {1'b0, a} + {1'b0, b};
            end
        end
    end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined binary adder tree: input capture stage plus one registered level per adder level.
// Define ADDER_TREE_ACC_EN to add the acc_clr/acc_sum running accumulator.
module adder_tree_pipe
    import adder_tree_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LEVELS   = DEF_LEVELS,
    parameter int ACC_BITS = DEF_ACC_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [(WIDTH<<LEVELS)-1:0]    in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH+LEVELS-1:0]       out_sum
`ifdef ADDER_TREE_ACC_EN
    ,
    input  logic                          acc_clr,
    output logic [WIDTH+LEVELS+ACC_BITS-1:0] acc_sum
`endif
);

    localparam int N       = 1 << LEVELS;
    localparam int SUM_W   = stage_w(WIDTH, LEVELS);
    localparam int OUT_OFF = level_off(WIDTH, N, LEVELS);
    localparam int BUS_W   = OUT_OFF + SUM_W;

    if (LEVELS < 1 || LEVELS > 6 || WIDTH < 1 || ACC_BITS < 0) begin : g_bad_cfg
        $error("adder_tree_pipe: illegal WIDTH/LEVELS/ACC_BITS");
    end

    // A full output register that is not being taken freezes the whole pipe.
    logic stall;
    logic adv;

    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = adv;

    // Every level's partial sums live back to back in one flat bus.
    logic [BUS_W-1:0] tree_bus;
    logic [LEVELS:0]  vld_lv;

    // Stage 0: operand capture
    logic [N*WIDTH-1:0] opnd_p0;
    logic               vld_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            opnd_p0 <= in_data;
        end
    end

    assign tree_bus[N*WIDTH-1:0] = opnd_p0;
    assign vld_lv[0]             = vld_p0;

    // Stages 1..LEVELS: adder levels, operands 2k and 2k+1 pair
    for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_lvl
        localparam int IW      = stage_w(WIDTH, lv - 1);
        localparam int NODES   = N >> lv;
        localparam int SRC_OFF = level_off(WIDTH, N, lv - 1);
        localparam int DST_OFF = level_off(WIDTH, N, lv);

        logic [NODES-1:0] node_vld;

        for (genvar nd = 0; nd < NODES; nd++) begin : g_node
            adder_tree_node #(
                .IN_W     (IW),
                .RST_DATA (lv == LEVELS)
            ) u_node (
                .clk     (clk),
                .rst     (rst),
                .en      (adv),
                .in_vld  (vld_lv[lv-1]),
                .a       (tree_bus[SRC_OFF + (2*nd)*IW     +: IW]),
                .b       (tree_bus[SRC_OFF + (2*nd + 1)*IW +: IW]),
                .out_vld (node_vld[nd]),
                .sum     (tree_bus[DST_OFF + nd*(IW + 1)   +: IW + 1])
            );
        end

        // All lanes of a level advance in lockstep, so their valid bits agree.
        assign vld_lv[lv] = &node_vld;
    end

    assign out_valid = vld_lv[LEVELS];
    assign out_sum   = tree_bus[OUT_OFF +: SUM_W];

`ifdef ADDER_TREE_ACC_EN
    localparam int ACC_W = SUM_W + ACC_BITS;

    logic out_xfer;

    assign out_xfer = out_valid & out_ready;

    // Clear wins over accumulate but still keeps a result leaving this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_sum <= '0;
        end else if (acc_clr) begin
            acc_sum <= out_xfer ? ACC_W'(out_sum) : '0;
        end else if (out_xfer) begin
            acc_sum <= acc_sum + ACC_W'(out_sum);
        end
    end
`endif

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Bench for adder_tree_pipe: default config with directed + random traffic, plus two
// parameter-sweep instances under random traffic, all checked against a queue model.
`timescale 1ns/1ps
module tb_adder_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar c = 0; c < 3; c++) begin : g_cfg
        localparam int W  = (c == 0) ? 15 : ((c == 1) ? 1 : 32);
        localparam int L  = (c == 0) ? 3 : ((c == 1) ? 1 : 6);
        localparam int N  = 1 << L;
        localparam int SW = W + L;
        localparam int AW = SW + 8;

        logic          rst;
        logic          in_valid;
        logic          in_ready;
        logic [N*W-1:0] in_data;
        logic          out_valid;
        logic          out_ready;
        logic [SW-1:0] out_sum;
        logic          done_flag = 1'b0;
`ifdef ADDER_TREE_ACC_EN
        logic          acc_clr;
        logic [AW-1:0] acc_sum;
        logic [AW-1:0] acc_m = '0;
`endif

        adder_tree_pipe #(.WIDTH(W), .LEVELS(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_sum   (out_sum)
`ifdef ADDER_TREE_ACC_EN
            ,
            .acc_clr   (acc_clr),
            .acc_sum   (acc_sum)
`endif
        );

        function automatic longint unsigned ref_sum(input logic [N*W-1:0] d);
            longint unsigned s;
            s = 0;
            for (int k = 0; k < N; k++) s += 64'(d[k*W +: W]);
            return s;
        endfunction

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic fill_const(input logic [W-1:0] v);
            for (int k = 0; k < N; k++) in_data[k*W +: W] = v;
        endtask

        task automatic rand_fill();
            logic [31:0] r;
            int mode;
            mode = $urandom_range(9);
            for (int k = 0; k < N; k++) begin
                r = $urandom;
                if (mode == 0)      in_data[k*W +: W] = '1;
                else if (mode == 1) in_data[k*W +: W] = '0;
                else                in_data[k*W +: W] = r[W-1:0];
            end
        endtask

        // Scoreboard: expected sums queued at input transfer, consumed at output transfer.
        longint unsigned exp_q[$];
        int              cyc_q[$];
        int              stall_q[$];
        int              cyc = 0;
        int              stalls = 0;
        logic            hold_pending = 1'b0;
        logic [SW-1:0]   hold_sum = '0;
        longint unsigned popped;
        logic            popped_ok;

        always @(negedge clk) begin
            cyc++;
            if (rst) begin
                exp_q.delete();
                cyc_q.delete();
                stall_q.delete();
                hold_pending = 1'b0;
`ifdef ADDER_TREE_ACC_EN
                acc_m = '0;
`endif
            end else begin
                popped_ok = 1'b0;
                popped    = 0;
                chk("no_x", 64'($isunknown({in_ready, out_valid, out_sum})), 0);
                chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
                if (hold_pending) begin
                    chk("hold_valid", 64'(out_valid), 1);
                    chk("hold_sum", 64'(out_sum), 64'(hold_sum));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out", 64'(out_valid), 0);
                    end else begin
                        popped    = exp_q.pop_front();
                        popped_ok = 1'b1;
                        chk("sum", 64'(out_sum), popped);
                        chk("latency", 64'((cyc - cyc_q.pop_front()) - (stalls - stall_q.pop_front())),
                            64'(L + 1));
                    end
                end
`ifdef ADDER_TREE_ACC_EN
                chk("acc_sum_model", 64'(acc_sum), 64'(acc_m));
                if (acc_clr)        acc_m = popped_ok ? AW'(popped) : '0;
                else if (popped_ok) acc_m = acc_m + AW'(popped);
`endif
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_sum(in_data));
                    cyc_q.push_back(cyc);
                    stall_q.push_back(stalls);
                end
                if (out_valid && !out_ready) stalls++;
                hold_pending = out_valid && !out_ready;
                hold_sum     = out_sum;
            end
        end

        if (c == 0) begin : g_dir
            initial begin : p_dir
                int lat;
                int cnt;
                rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
`ifdef ADDER_TREE_ACC_EN
                acc_clr = 1'b0;
`endif
                repeat (3) @(negedge clk);
                chk("rst_out_valid", 64'(out_valid), 0);
                chk("rst_out_sum", 64'(out_sum), 0);
                chk("rst_in_ready", 64'(in_ready), 1);
`ifdef ADDER_TREE_ACC_EN
                chk("rst_acc_sum", 64'(acc_sum), 0);
`endif
                step();
                rst = 1'b0;

                // all-maximum operands, single transfer
                fill_const('1); in_valid = 1'b1; step(); in_valid = 1'b0;
                lat = 1; @(negedge clk);
                while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
                chk("max_latency", 64'(lat), 4);
                chk("max_sum", 64'(out_sum), 64'h3FFF8);
                step();

                // ordering: k+1 then all 100, back to back
                for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(k + 1);
                in_valid = 1'b1; step();
                fill_const(W'(100)); step(); in_valid = 1'b0;
                cnt = 0; @(negedge clk);
                while (!out_valid && cnt < 20) begin @(negedge clk); cnt++; end
                chk("order_first", 64'(out_sum), 36);
                @(negedge clk);
                chk("order_second_valid", 64'(out_valid), 1);
                chk("order_second", 64'(out_sum), 800);
                step();

                // backpressure: out_ready low for 5 cycles under continuous input
                repeat (6) step();
                cnt = 0;
                for (int i = 0; i < 15; i++) begin
                    rand_fill(); in_valid = 1'b1; out_ready = !(i >= 6 && i < 11);
                    @(negedge clk);
                    if (i >= 6 && i < 11 && !in_ready) cnt++;
                    step();
                end
                in_valid = 1'b0; out_ready = 1'b1;
                chk("bp_in_ready_low", 64'(cnt), 5);
                repeat (10) step();

                // asynchronous reset with three sets in flight
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin rand_fill(); in_valid = 1'b1; step(); end
                in_valid = 1'b0;
                cnt = 0; @(negedge clk);
                while (!out_valid && cnt < 20) begin @(negedge clk); cnt++; end
                chk("rst_pre_valid", 64'(out_valid), 1);
                #2 rst = 1'b1;
                #1;
                chk("rst_async_valid", 64'(out_valid), 0);
                chk("rst_async_sum", 64'(out_sum), 0);
                step(); step();
                rst = 1'b0; out_ready = 1'b1;
                cnt = 0;
                repeat (10) begin @(negedge clk); if (out_valid) cnt++; end
                chk("rst_no_emit", 64'(cnt), 0);
                step();

                // random traffic with random backpressure
                for (int i = 0; i < 400; i++) begin
                    rand_fill();
                    in_valid  = ($urandom_range(3) != 0);
                    out_ready = ($urandom_range(3) != 0);
                    step();
                end
                in_valid = 1'b0; out_ready = 1'b1;
                repeat (10) step();

`ifdef ADDER_TREE_ACC_EN
                acc_clr = 1'b1; step(); acc_clr = 1'b0;
                @(negedge clk);
                chk("acc_clear", 64'(acc_sum), 0);
                step();
                for (int i = 1; i <= 3; i++) begin
                    in_data = '0; in_data[W-1:0] = W'(10 * i); in_valid = 1'b1; step();
                end
                in_valid = 1'b0;
                repeat (8) step();
                @(negedge clk);
                chk("acc_60", 64'(acc_sum), 60);
                step();

                out_ready = 1'b0;
                in_data = '0; in_data[W-1:0] = W'(5); in_valid = 1'b1; step(); in_valid = 1'b0;
                cnt = 0; @(negedge clk);
                while (!out_valid && cnt < 20) begin @(negedge clk); cnt++; end
                step();
                acc_clr = 1'b1; out_ready = 1'b1; step(); acc_clr = 1'b0;
                @(negedge clk);
                chk("acc_clr_with_result", 64'(acc_sum), 5);
                step();

                repeat (6) step();
                acc_clr = 1'b1; step(); acc_clr = 1'b0;
                fill_const('1); in_valid = 1'b1;
                repeat (257) step();
                in_valid = 1'b0;
                repeat (8) step();
                @(negedge clk);
                chk("acc_wrap", 64'(acc_sum), (64'd257 * 64'h3FFF8) % (64'd1 << 26));
                step();
`endif
                done_flag = 1'b1;
            end
        end else begin : g_rnd
            initial begin : p_rnd
                int lat;
                rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
`ifdef ADDER_TREE_ACC_EN
                acc_clr = 1'b0;
`endif
                repeat (3) @(negedge clk);
                chk("sweep_rst_valid", 64'(out_valid), 0);
                chk("sweep_rst_sum", 64'(out_sum), 0);
                step();
                rst = 1'b0;

                fill_const('1); in_valid = 1'b1; step(); in_valid = 1'b0;
                lat = 1; @(negedge clk);
                while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
                chk("sweep_latency", 64'(lat), 64'(L + 1));
                chk("sweep_max_sum", 64'(out_sum), 64'(N) * ((64'd1 << W) - 1));
                step();

                for (int i = 0; i < 500; i++) begin
                    rand_fill();
                    in_valid  = ($urandom_range(3) != 0);
                    out_ready = ($urandom_range(3) != 0);
                    step();
                end
                in_valid = 1'b0; out_ready = 1'b1;
                repeat (12) step();
                done_flag = 1'b1;
            end
        end
    end

    initial begin
        wait (g_cfg[0].done_flag && g_cfg[1].done_flag && g_cfg[2].done_flag);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge clk);
        failures++;
        $display("FAIL watchdog: stimulus did not complete within 20000 cycles");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
